// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, oversampled) feeding a small receive FIFO with valid/ready pop.
// Build option: define UART_RX_FIFO_DEPTH4_EN for a 4-entry FIFO; otherwise a single holding register.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ    = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned SAMPLING_RATE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RsRx,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       receiving,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned DIV    = CLOCK_FREQ / (BAUD_RATE * SAMPLING_RATE);
  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W  = $clog2(SAMPLING_RATE);
`ifdef UART_RX_FIFO_DEPTH4_EN
  localparam int unsigned DEPTH  = 4;
`else
  localparam int unsigned DEPTH  = 1;
`endif
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  state_e            state_q, state_d;
  logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              receiving_q, receiving_d;
  logic              frame_error_q, frame_error_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        mem_q [DEPTH];

  logic tick_c;
  logic push_c;
  logic ferr_c;
  logic pop_c;
  logic full_c;
  logic wr_en_c;

  assign tick_c = (tick_cnt_q == TICK_W'(DIV - 1));

  // Synchronizer and free-running oversample tick; never realigned to the start edge.
  always_comb begin
    rx_meta_d  = RsRx;
    rx_s_d     = rx_meta_q;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Frame FSM: counts ticks within each state, samples mid-bit after the start check.
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_c    = 1'b0;
    ferr_c    = 1'b0;
    if (tick_c) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d   = START;
            smp_cnt_d = '0;
          end
        end
        START: begin
          if (smp_cnt_q == SMP_W'(SAMPLING_RATE / 2 - 1)) begin
            smp_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = rx_s_q ? IDLE : DATA;
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
        DATA: begin
          if (smp_cnt_q == SMP_W'(SAMPLING_RATE - 1)) begin
            smp_cnt_d = '0;
            shift_d   = {rx_s_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d   = STOP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
        STOP: begin
          if (smp_cnt_q == SMP_W'(SAMPLING_RATE - 1)) begin
            smp_cnt_d = '0;
            state_d   = IDLE;
            push_c    = rx_s_q;
            ferr_c    = !rx_s_q;
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          smp_cnt_d = '0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: a pop frees a slot in the same cycle, so push+pop succeeds when full.
  assign pop_c   = valid_q && ready;
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign wr_en_c = push_c && (!full_c || pop_c);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (wr_en_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    unique case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d       = (count_d != '0);
    receiving_d   = (state_d != IDLE);
    frame_error_d = ferr_c;
    overrun_d     = push_c && full_c && !pop_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      tick_cnt_q    <= '0;
      state_q       <= IDLE;
      smp_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      receiving_q   <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      tick_cnt_q    <= tick_cnt_d;
      state_q       <= state_d;
      smp_cnt_q     <= smp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      receiving_q   <= receiving_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  // Storage needs no reset: contents are only observed while valid is high.
  always_ff @(posedge clk) begin
    if (wr_en_c && !reset) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign data_out    = mem_q[rd_ptr_q];
  assign valid       = valid_q;
  assign receiving   = receiving_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level reference model (tick arithmetic + byte queue) checked every cycle.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned CLOCK_FREQ = 7_372_800;
  localparam int unsigned BAUD_RATE  = 115200;
  localparam int unsigned SR         = 16;
  localparam int unsigned DIV        = CLOCK_FREQ / (BAUD_RATE * SR);
  localparam int unsigned BIT        = DIV * SR;
`ifdef UART_RX_FIFO_DEPTH4_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RsRx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       receiving;
  logic       frame_error;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLOCK_FREQ   (CLOCK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .SAMPLING_RATE(SR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RsRx       (RsRx),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .receiving  (receiving),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge n after reset is a tick when n % DIV == 0; sample points are
  // tick offsets from the start-detection tick (start check at SR/2, bit i at SR/2+SR*(i+1)).
  int unsigned n;
  int unsigned k0;
  int unsigned stop_edge;
  logic        m1, m2;
  bit          busy;
  bit          model_live = 1'b0;
  logic [7:0]  asm_b;
  logic [7:0]  mq[$];
  bit          exp_fe, exp_ov;

  always @(posedge clk) begin
    if (reset) begin
      n = 0; m1 = 1'b1; m2 = 1'b1; busy = 1'b0;
      mq.delete(); exp_fe = 1'b0; exp_ov = 1'b0; model_live = 1'b1;
    end else begin
      logic rxs;
      bit   pop, push, fe;
      int   off;
      int unsigned k;
      n++;
      rxs  = m2;
      pop  = (mq.size() != 0) && ready;
      push = 1'b0;
      fe   = 1'b0;
      if (n % DIV == 0) begin
        k = n / DIV;
        if (!busy) begin
          if (!rxs) begin
            busy = 1'b1; k0 = k;
            stop_edge = (k0 + SR / 2 + 9 * SR) * DIV;
          end
        end else begin
          off = int'(k) - int'(k0) - int'(SR / 2);
          if (off == 0) begin
            if (rxs) busy = 1'b0;
          end else if (off > 0 && off % SR == 0) begin
            if (off / SR <= 8) asm_b[off / SR - 1] = rxs;
            else begin
              busy = 1'b0;
              if (rxs) push = 1'b1; else fe = 1'b1;
            end
          end
        end
      end
      exp_fe = fe;
      exp_ov = push && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (push && !exp_ov) mq.push_back(asm_b);
      m2 = m1;
      m1 = RsRx;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("valid", valid, mq.size() != 0);
      if (mq.size() != 0) check("data_out", data_out, mq[0]);
      check("receiving", receiving, busy);
      check("frame_error", frame_error, exp_fe);
      check("overrun", overrun, exp_ov);
      if (frame_error) fe_seen++;
      if (overrun) ov_seen++;
    end
  end

  logic [7:0] popped[$];

  task automatic wait_cyc(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_stop);
    RsRx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      wait_cyc(BIT);
    end
    if (good_stop) begin
      RsRx = 1'b1;
      wait_cyc(BIT);
    end else begin
      RsRx = 1'b0;
      wait_cyc(BIT * 3 / 4);
      RsRx = 1'b1;
      wait_cyc(BIT / 4);
    end
  endtask

  task automatic drain();
    popped.delete();
    ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (!valid) break;
      popped.push_back(data_out);
      @(negedge clk);
    end
    ready = 1'b0;
    check("drain_empty", valid, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         good;
    int         fe0, ov0;

    @(negedge clk);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    check("rst_valid", valid, 1'b0);
    check("rst_receiving", receiving, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    wait_cyc(BIT);

    // Single good frame with ready low
    send_frame(8'h41, 1'b1);
    wait_cyc(BIT);
    check("f41_model_size", mq.size(), 1);
    check("f41_model_head", mq[0], 8'h41);
    check("f41_valid", valid, 1'b1);
    check("f41_data", data_out, 8'h41);
    check("f41_receiving", receiving, 1'b0);
    check("f41_no_fe", fe_seen, 0);
    drain();
    check("f41_pops", popped.size(), 1);
    check("f41_pop0", popped[0], 8'h41);

    // Short low glitch is rejected
    RsRx = 1'b0;
    wait_cyc(3 * DIV);
    RsRx = 1'b1;
    wait_cyc(2 * BIT);
    check("glitch_valid", valid, 1'b0);
    check("glitch_receiving", receiving, 1'b0);
    check("glitch_no_fe", fe_seen, 0);

    // Bad stop bit
    fe0 = fe_seen;
    send_frame(8'h55, 1'b0);
    wait_cyc(2 * BIT);
    check("bad_stop_fe_cycles", fe_seen - fe0, 1);
    check("bad_stop_valid", valid, 1'b0);

    // Overflow with ready low: only the first DEPTH bytes are kept
    ov0 = ov_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    wait_cyc(BIT);
    check("ovf_pulses", ov_seen - ov0, 5 - DEPTH);
    check("ovf_model_size", mq.size(), DEPTH);
    drain();
    check("ovf_pops", popped.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) check("ovf_pop_data", popped[i], 32'(i + 1));

    // Full FIFO with a pop on the exact push cycle of 0x66
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h61 + i), 1'b1);
    wait_cyc(BIT);
    ov0 = ov_seen;
    fork
      send_frame(8'h66, 1'b1);
      for (int c = 0; c < 11 * BIT; c++) begin
        @(negedge clk);
        ready = busy && (stop_edge == n + 1);
      end
    join
    ready = 1'b0;
    check("fullpp_no_ovf", ov_seen - ov0, 0);
    check("fullpp_model_size", mq.size(), DEPTH);
    drain();
    check("fullpp_pops", popped.size(), DEPTH);
    check("fullpp_last", popped[popped.size() - 1], 8'h66);

    // Reset during data bit 4 of 0x3C, then a clean 0x7E
    b = 8'h3C;
    RsRx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      RsRx = b[i];
      wait_cyc(BIT);
    end
    RsRx = b[4];
    wait_cyc(BIT / 2);
    reset = 1'b1;
    RsRx  = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2 * BIT);
    check("rstmid_valid", valid, 1'b0);
    check("rstmid_receiving", receiving, 1'b0);
    fe0 = fe_seen;
    send_frame(8'h7E, 1'b1);
    wait_cyc(BIT);
    check("f7e_valid", valid, 1'b1);
    check("f7e_data", data_out, 8'h7E);
    check("f7e_no_fe", fe_seen - fe0, 0);
    drain();

    // Randomized frames, gaps and consumer back-pressure
    for (int f = 0; f < 25; f++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      fork
        send_frame(b, good);
        for (int c = 0; c < 10 * BIT; c++) begin
          @(negedge clk);
          ready = ($urandom_range(0, 3) == 0);
        end
      join
      ready = $urandom_range(0, 1) != 0;
      wait_cyc($urandom_range(good ? 0 : 2 * BIT, 2 * BIT));
      ready = 1'b0;
    end
    wait_cyc(2 * BIT);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
